// File: rtl/seq_mem_loader_pkg.sv
// rtl/seq_mem_loader_pkg.sv - shared codes and state type for the base memory loader
package seq_mem_loader_pkg;

  // 'N' base; also the padding code seen by the k-mer extension logic
  localparam logic [3:0] BASE_N = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/seq_mem_loader.sv
// rtl/seq_mem_loader.sv - streams encoded bases into a packed slot memory, slot n <= base n
module seq_mem_loader
  import seq_mem_loader_pkg::*;
#(
  parameter int BASE_LEN   = 4,
  parameter int ACTUAL_MEM = 32,
  parameter int MEM_LEN    = ACTUAL_MEM * BASE_LEN,
  parameter int INDICE_LEN = $clog2(ACTUAL_MEM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  base_valid,
  input  logic [BASE_LEN-1:0]   base_data,
  input  logic                  base_last,
  output logic                  base_ready,
  output logic [MEM_LEN-1:0]    memory,
  output logic                  mem_valid,
  output logic [INDICE_LEN:0]   wr_count,
  output logic                  truncated
);

  localparam logic [INDICE_LEN:0]   CAP_M1   = (INDICE_LEN+1)'(ACTUAL_MEM - 1);
  localparam logic [ACTUAL_MEM-1:0] SLOT_ONE = {{(ACTUAL_MEM-1){1'b0}}, 1'b1};

  loader_state_t         state_q, state_d;
  logic [MEM_LEN-1:0]    mem_q, mem_d;
  logic [INDICE_LEN:0]   cnt_q, cnt_d;
  logic                  trunc_q, trunc_d;
  logic [ACTUAL_MEM-1:0] slot_we;
  logic                  at_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    slot_we = '0;
    at_cap  = (cnt_q == CAP_M1);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mem_d   = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // cnt_q < ACTUAL_MEM while loading, so the low bits are a valid slot index
        if (base_valid) begin
          slot_we = SLOT_ONE << cnt_q[INDICE_LEN-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (base_last || at_cap) begin
            state_d = DONE;
            trunc_d = at_cap && !base_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    for (int s = 0; s < ACTUAL_MEM; s++) begin
      if (slot_we[s]) mem_d[s*BASE_LEN +: BASE_LEN] = base_data;
    end
  end

  assign base_ready = (state_q == LOAD);
  assign mem_valid  = (state_q == DONE);
  assign memory     = mem_q;
  assign wr_count   = cnt_q;
  assign truncated  = trunc_q;

endmodule

// File: tb/tb_seq_mem_loader.sv
// tb/tb_seq_mem_loader.sv - self-checking bench for seq_mem_loader
module tb_seq_mem_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         base_valid;
  logic [3:0]   base_data;
  logic         base_last;
  logic         base_ready;
  logic [127:0] memory;
  logic         mem_valid;
  logic [5:0]   wr_count;
  logic         truncated;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int         slot;
    logic [3:0] data;
  } sb_item_t;
  sb_item_t sb[$];

  typedef struct {
    logic       start;
    logic       valid;
    logic [3:0] data;
    logic       last;
    logic       exp_ready;
    logic [5:0] exp_cnt;
    logic       exp_mv;
    logic       exp_tr;
  } vec_t;
  vec_t vecs[9];

  seq_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_valid (base_valid),
    .base_data  (base_data),
    .base_last  (base_last),
    .base_ready (base_ready),
    .memory     (memory),
    .mem_valid  (mem_valid),
    .wr_count   (wr_count),
    .truncated  (truncated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; base_valid = 0; base_data = 4'h0; base_last = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic beat(input int slot, input logic [3:0] d, input logic l);
    base_valid = 1; base_data = d; base_last = l;
    sb.push_back('{slot, d});
    step();
    base_valid = 0; base_last = 0;
  endtask

  task automatic check_image(input string name);
    logic [127:0] exp;
    sb_item_t it;
    exp = '0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      exp[it.slot*4 +: 4] = it.data;
    end
    chk(name, memory, exp);
  endtask

  initial begin
    logic [127:0] snap;
    logic         prev_ready;

    // Table: start, valid, data, last, then post-edge ready/count/mem_valid/truncated
    vecs[0] = '{1, 0, 4'h0, 0, 1, 6'd0, 0, 0};
    vecs[1] = '{0, 1, 4'h1, 0, 1, 6'd1, 0, 0};
    vecs[2] = '{0, 0, 4'h2, 0, 1, 6'd1, 0, 0};
    vecs[3] = '{0, 1, 4'h2, 0, 1, 6'd2, 0, 0};
    vecs[4] = '{0, 1, 4'h4, 0, 1, 6'd3, 0, 0};
    vecs[5] = '{0, 0, 4'h8, 0, 1, 6'd3, 0, 0};
    vecs[6] = '{0, 1, 4'h8, 0, 1, 6'd4, 0, 0};
    vecs[7] = '{0, 1, 4'h1, 1, 0, 6'd5, 1, 0};
    vecs[8] = '{0, 1, 4'h8, 1, 0, 6'd5, 1, 0};

    rst = 1;
    idle_inputs();
    #3;
    chk("reset_ready", 128'(base_ready), 128'(0));
    chk("reset_mem", memory, '0);
    chk("reset_mv_cnt_tr", 128'({mem_valid, wr_count, truncated}), 128'(0));
    @(posedge clk); #1;
    rst = 0;
    step();
    chk("idle_ready", 128'(base_ready), 128'(0));

    prev_ready = 0;
    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start; base_valid = vecs[i].valid;
      base_data = vecs[i].data; base_last = vecs[i].last;
      if (vecs[i].valid && prev_ready) sb.push_back('{int'(vecs[i-1].exp_cnt), vecs[i].data});
      step();
      chk($sformatf("vec%0d_ready", i), 128'(base_ready), 128'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_cnt", i), 128'(wr_count), 128'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_mv", i), 128'(mem_valid), 128'(vecs[i].exp_mv));
      chk($sformatf("vec%0d_tr", i), 128'(truncated), 128'(vecs[i].exp_tr));
      prev_ready = vecs[i].exp_ready;
    end
    idle_inputs();
    check_image("five_base_image");

    // Restart from DONE clears the image in the very next cycle
    pulse_start();
    chk("restart_mem", memory, '0);
    chk("restart_mv", 128'(mem_valid), 128'(0));
    chk("restart_ready", 128'(base_ready), 128'(1));
    beat(0, 4'h3, 0);
    beat(1, 4'h5, 1);
    chk("two_base_cnt", 128'(wr_count), 128'(2));
    chk("two_base_mv", 128'(mem_valid), 128'(1));
    check_image("two_base_image");

    // Capacity reached without last
    pulse_start();
    for (int i = 0; i < 32; i++) beat(i, 4'h2, 0);
    chk("trunc_flag", 128'(truncated), 128'(1));
    chk("trunc_cnt", 128'(wr_count), 128'(32));
    chk("trunc_ready", 128'(base_ready), 128'(0));
    chk("trunc_mv", 128'(mem_valid), 128'(1));
    check_image("trunc_image");
    snap = {32{4'h2}};
    base_valid = 1; base_data = 4'h8; base_last = 0;
    step(); step();
    idle_inputs();
    chk("after_done_mem", memory, snap);
    chk("after_done_cnt", 128'(wr_count), 128'(32));

    // Full capacity with last on the final beat is not a truncation
    pulse_start();
    for (int i = 0; i < 32; i++) beat(i, 4'(i % 15 + 1), (i == 31));
    chk("full_last_tr", 128'(truncated), 128'(0));
    chk("full_last_mv", 128'(mem_valid), 128'(1));
    chk("full_last_cnt", 128'(wr_count), 128'(32));
    check_image("full_last_image");

    // Asynchronous reset in the middle of a load
    pulse_start();
    beat(0, 4'h7, 0);
    beat(1, 4'h9, 0);
    beat(2, 4'hA, 0);
    chk("midload_cnt", 128'(wr_count), 128'(3));
    #2 rst = 1;
    #1;
    chk("async_rst_mem", memory, '0);
    chk("async_rst_ready", 128'(base_ready), 128'(0));
    chk("async_rst_mv_cnt_tr", 128'({mem_valid, wr_count, truncated}), 128'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    base_valid = 1; base_data = 4'hF; base_last = 0;
    step(); step();
    idle_inputs();
    chk("post_rst_cnt", 128'(wr_count), 128'(0));
    chk("post_rst_mem", memory, '0);
    chk("post_rst_ready", 128'(base_ready), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
